// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive deserializer: FSM states, SYNC pattern,
// default packet length limit and the PID nibble-check helper.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

  localparam logic [7:0] SYNC_PATTERN      = 8'h80;
  localparam int         MAX_BYTES_DEFAULT = 1026;

  // A PID is well formed when its upper nibble is the complement of its lower nibble.
  function automatic logic pid_nibble_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/usb_sync_detect.sv
// SYNC hunter: shifts accepted bits in at the MSB end and pulses match_o in the
// same cycle the bit that completes SYNC_PATTERN arrives.
module usb_sync_detect
  import usb_rx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic bit_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic match_o
);

  logic [7:0] hist_q;
  logic [7:0] hist_d;

  assign hist_d  = {bit_i, hist_q[7:1]};
  assign match_o = enable_i && (hist_d == SYNC_PATTERN);

  // History is emptied on a match so a later return to HUNT starts clean.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || match_o) begin
      hist_q <= '0;
    end else if (enable_i) begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// USB receive deserializer: finds SYNC, assembles LSB-first bytes and flags packet end.
// Optional PID nibble check is enabled by defining RX_DESER_PID_CHECK_EN.
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic       Rx_Deser_Clk,
  input  logic       Rx_Deser_Rst,
  input  logic       Rx_Deser_Data_In,
  input  logic       Rx_Deser_Skip_In,
  input  logic       Rx_Deser_Eop_In,
  output logic [7:0] Rx_Deser_Byte_Out,
  output logic       Rx_Deser_Valid_Out,
  output logic       Rx_Deser_First_Out,
  output logic       Rx_Deser_Active_Out,
  output logic       Rx_Deser_Done_Out,
  output logic       Rx_Deser_Err_Out
`ifdef RX_DESER_PID_CHECK_EN
  , output logic     Rx_Deser_Pid_Err_Out
`endif
);

  localparam int            CW      = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

  rx_state_e     state_q;
  logic [2:0]    bitCnt_q;
  logic [CW-1:0] byteCnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          first_q;
  logic          active_q;
  logic          done_q;
  logic          err_q;
  logic          accept;
  logic          syncMatch;
  logic          pidClean;

  assign accept  = !Rx_Deser_Skip_In && !Rx_Deser_Eop_In;
  assign shift_d = {Rx_Deser_Data_In, shift_q[7:1]};

  usb_sync_detect u_sync (
    .clk_i    (Rx_Deser_Clk),
    .rst_i    (Rx_Deser_Rst),
    .bit_i    (Rx_Deser_Data_In),
    .enable_i (accept && (state_q == HUNT)),
    .clear_i  (Rx_Deser_Eop_In),
    .match_o  (syncMatch)
  );

`ifdef RX_DESER_PID_CHECK_EN
  logic pidErr_q;
  logic pidBad_q;
  assign Rx_Deser_Pid_Err_Out = pidErr_q;
  assign pidClean             = !pidBad_q;
`else
  assign pidClean = 1'b1;
`endif

  always_ff @(posedge Rx_Deser_Clk) begin
    if (Rx_Deser_Rst) begin
      state_q   <= HUNT;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef RX_DESER_PID_CHECK_EN
      pidErr_q  <= 1'b0;
      pidBad_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef RX_DESER_PID_CHECK_EN
      pidErr_q <= 1'b0;
`endif
      case (state_q)
        HUNT: begin
          if (syncMatch) begin
            state_q   <= DATA;
            active_q  <= 1'b1;
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
`ifdef RX_DESER_PID_CHECK_EN
            pidBad_q  <= 1'b0;
`endif
          end
        end
        DATA: begin
          // Eop wins over a coinciding bit; only a byte-aligned, non-empty packet ends clean.
          if (Rx_Deser_Eop_In) begin
            state_q  <= HUNT;
            active_q <= 1'b0;
            bitCnt_q <= '0;
            if ((bitCnt_q == 3'd0) && (byteCnt_q != '0) && pidClean) begin
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (accept) begin
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (byteCnt_q == MAX_CNT) begin
                err_q   <= 1'b1;
                state_q <= DRAIN;
              end else begin
                byte_q    <= shift_d;
                valid_q   <= 1'b1;
                first_q   <= (byteCnt_q == '0);
                byteCnt_q <= byteCnt_q + 1'b1;
`ifdef RX_DESER_PID_CHECK_EN
                if ((byteCnt_q == '0) && !pid_nibble_ok(shift_d)) begin
                  pidErr_q <= 1'b1;
                  pidBad_q <= 1'b1;
                end
`endif
              end
            end
          end
        end
        DRAIN: begin
          if (Rx_Deser_Eop_In) begin
            state_q  <= HUNT;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= HUNT;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign Rx_Deser_Byte_Out   = byte_q;
  assign Rx_Deser_Valid_Out  = valid_q;
  assign Rx_Deser_First_Out  = first_q;
  assign Rx_Deser_Active_Out = active_q;
  assign Rx_Deser_Done_Out   = done_q;
  assign Rx_Deser_Err_Out    = err_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Directed bench for usb_rx_deserializer (MAX_BYTES=4) with an event scoreboard;
// honours RX_DESER_PID_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_usb_rx_deserializer;

  localparam int EV_BYTE = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       first;
    logic       pidErr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       dataIn;
  logic       skipIn;
  logic       eopIn;
  logic [7:0] byteOut;
  logic       validOut;
  logic       firstOut;
  logic       activeOut;
  logic       doneOut;
  logic       errOut;
`ifdef RX_DESER_PID_CHECK_EN
  logic       pidErrOut;
`endif

  int  checks = 0;
  int  errors = 0;
  ev_t sbQ[$];

  always #5 clk = ~clk;

  usb_rx_deserializer #(.MAX_BYTES(4)) dut (
    .Rx_Deser_Clk        (clk),
    .Rx_Deser_Rst        (rst),
    .Rx_Deser_Data_In    (dataIn),
    .Rx_Deser_Skip_In    (skipIn),
    .Rx_Deser_Eop_In     (eopIn),
    .Rx_Deser_Byte_Out   (byteOut),
    .Rx_Deser_Valid_Out  (validOut),
    .Rx_Deser_First_Out  (firstOut),
    .Rx_Deser_Active_Out (activeOut),
    .Rx_Deser_Done_Out   (doneOut),
    .Rx_Deser_Err_Out    (errOut)
`ifdef RX_DESER_PID_CHECK_EN
    , .Rx_Deser_Pid_Err_Out (pidErrOut)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectEvent(input int kind, input logic [7:0] data, input logic first);
    ev_t e;
    e.kind   = kind;
    e.data   = data;
    e.first  = first;
`ifdef RX_DESER_PID_CHECK_EN
    e.pidErr = first && (data[7:4] !== ~data[3:0]);
`else
    e.pidErr = 1'b0;
`endif
    sbQ.push_back(e);
  endtask

  task automatic matchEvent(input int kind);
    ev_t e;
    checkOutput("event_expected", 32'(sbQ.size() > 0), 32'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("event_kind", 32'(kind), 32'(e.kind));
      if ((kind == EV_BYTE) && (e.kind == EV_BYTE)) begin
        checkOutput("byte_out", 32'(byteOut), 32'(e.data));
        checkOutput("first_out", 32'(firstOut), 32'(e.first));
`ifdef RX_DESER_PID_CHECK_EN
        checkOutput("pid_err_out", 32'(pidErrOut), 32'(e.pidErr));
`endif
      end
    end
  endtask

  // Scoreboard monitor samples on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (validOut === 1'b1) matchEvent(EV_BYTE);
    if (doneOut === 1'b1) matchEvent(EV_DONE);
    if (errOut === 1'b1) matchEvent(EV_ERR);
  end

  task automatic applyStimulus(input logic d, input logic s, input logic e);
    dataIn = d;
    skipIn = s;
    eopIn  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic sendSync();
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) applyStimulus(b[i], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_byte"}, 32'(byteOut), 32'd0);
    checkOutput({tag, "_valid"}, 32'(validOut), 32'd0);
    checkOutput({tag, "_first"}, 32'(firstOut), 32'd0);
    checkOutput({tag, "_active"}, 32'(activeOut), 32'd0);
    checkOutput({tag, "_done"}, 32'(doneOut), 32'd0);
    checkOutput({tag, "_err"}, 32'(errOut), 32'd0);
  endtask

  initial begin
    logic [7:0] e1;
    e1     = 8'hE1;
    rst    = 1'b1;
    dataIn = 1'b0;
    skipIn = 1'b1;
    eopIn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] Eop while hunting is ignored");
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("hunt_eop_active", 32'(activeOut), 32'd0);
    idle(2);

    $display("[TB] Two byte packet A5 3C");
    sendSync();
    checkOutput("sync_active", 32'(activeOut), 32'd1);
    expectEvent(EV_BYTE, 8'hA5, 1'b1);
    sendByte(8'hA5);
    checkOutput("a5_valid", 32'(validOut), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("hold_byte", 32'(byteOut), 32'hA5);
    checkOutput("valid_one_cycle", 32'(validOut), 32'd0);
    expectEvent(EV_BYTE, 8'h3C, 1'b0);
    sendByte(8'h3C);
    expectEvent(EV_DONE, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("eop_done", 32'(doneOut), 32'd1);
    checkOutput("eop_inactive", 32'(activeOut), 32'd0);
    idle(3);

    $display("[TB] Byte E1 with two skip slots");
    sendSync();
    expectEvent(EV_BYTE, 8'hE1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(e1[i], 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("skip_active", 32'(activeOut), 32'd1);
    for (int i = 4; i < 7; i++) applyStimulus(e1[i], 1'b0, 1'b0);
    checkOutput("skip_no_early_valid", 32'(validOut), 32'd0);
    applyStimulus(e1[7], 1'b0, 1'b0);
    checkOutput("skip_valid", 32'(validOut), 32'd1);
    checkOutput("skip_byte", 32'(byteOut), 32'hE1);
    expectEvent(EV_DONE, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(3);

    $display("[TB] Partial byte before Eop");
    sendSync();
    expectEvent(EV_BYTE, 8'hD2, 1'b1);
    sendByte(8'hD2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectEvent(EV_ERR, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("partial_err", 32'(errOut), 32'd1);
    checkOutput("partial_no_done", 32'(doneOut), 32'd0);
    checkOutput("partial_no_valid", 32'(validOut), 32'd0);
    idle(3);

    $display("[TB] Eop with zero bytes");
    sendSync();
    expectEvent(EV_ERR, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("empty_err", 32'(errOut), 32'd1);
    idle(3);

    $display("[TB] Overlength packet");
    sendSync();
    expectEvent(EV_BYTE, 8'hC3, 1'b1);
    sendByte(8'hC3);
    expectEvent(EV_BYTE, 8'h22, 1'b0);
    sendByte(8'h22);
    expectEvent(EV_BYTE, 8'h33, 1'b0);
    sendByte(8'h33);
    expectEvent(EV_BYTE, 8'h44, 1'b0);
    sendByte(8'h44);
    expectEvent(EV_ERR, 8'h00, 1'b0);
    sendByte(8'h5A);
    checkOutput("over_err", 32'(errOut), 32'd1);
    checkOutput("over_no_valid", 32'(validOut), 32'd0);
    checkOutput("over_active", 32'(activeOut), 32'd1);
    sendByte(8'hFF);
    checkOutput("drain_active", 32'(activeOut), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("drain_eop_inactive", 32'(activeOut), 32'd0);
    checkOutput("drain_eop_no_done", 32'(doneOut), 32'd0);
    checkOutput("drain_eop_no_err", 32'(errOut), 32'd0);
    idle(3);

    $display("[TB] Reset in the middle of a packet");
    sendSync();
    expectEvent(EV_BYTE, 8'hA5, 1'b1);
    sendByte(8'hA5);
    expectEvent(EV_BYTE, 8'h12, 1'b0);
    sendByte(8'h12);
    expectEvent(EV_BYTE, 8'h34, 1'b0);
    sendByte(8'h34);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAllZero("midreset");
    rst = 1'b0;
    idle(2);
    checkAllZero("postreset");
    sendSync();
    expectEvent(EV_BYTE, 8'h69, 1'b1);
    sendByte(8'h69);
    expectEvent(EV_DONE, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("after_reset_done", 32'(doneOut), 32'd1);
    idle(3);

    $display("[TB] PID 55 packet");
    sendSync();
    expectEvent(EV_BYTE, 8'h55, 1'b1);
    sendByte(8'h55);
`ifdef RX_DESER_PID_CHECK_EN
    checkOutput("pid55_pid_err", 32'(pidErrOut), 32'd1);
    expectEvent(EV_ERR, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pid55_err", 32'(errOut), 32'd1);
    checkOutput("pid55_no_done", 32'(doneOut), 32'd0);
`else
    expectEvent(EV_DONE, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pid55_done", 32'(doneOut), 32'd1);
`endif
    idle(5);

    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_deserializer.md
USB_RX_DESERIALIZER -- requirements
Module: usb_rx_deserializer

Interface
REQ-001 Parameter MAX_BYTES, default 1026, SHALL be the maximum number of bytes per packet: PID + 1023 payload + 2 CRC.
REQ-002 Rx_Deser_Clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-003 Rx_Deser_Rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Rx_Deser_Data_In  input  1  SHALL be the unstuffed serial bit from the bit unstuffer, one per clock.
REQ-005 Rx_Deser_Skip_In  input  1  SHALL mark the current bit slot as a removed stuff bit; Data_In is ignored when it is high.
REQ-006 Rx_Deser_Eop_In  input  1  SHALL be a one-cycle end-of-packet strobe from the line receiver.
REQ-007 Rx_Deser_Byte_Out  output  8  SHALL carry the assembled byte, LSB received first.
REQ-008 Rx_Deser_Valid_Out  output  1  SHALL pulse for one cycle when Byte_Out is new.
REQ-009 Rx_Deser_First_Out  output  1  SHALL be high with Valid_Out for the first byte (PID) only.
REQ-010 Rx_Deser_Active_Out  output  1  SHALL be high from SYNC match until packet end.
REQ-011 Rx_Deser_Done_Out  output  1  SHALL pulse for one cycle on a clean packet end.
REQ-012 Rx_Deser_Err_Out  output  1  SHALL pulse for one cycle on an errored packet end or on overlength.

Function
REQ-013 States SHALL be HUNT, DATA and DRAIN.
REQ-014 An accepted bit SHALL be a cycle with Skip_In=0 and Eop_In=0.
REQ-015 In HUNT, accepted bits SHALL shift MSB-first into an 8-bit history register; SYNC matches when the last 8 accepted bits are 0,0,0,0,0,0,0,1 in arrival order (register value 8'h80).
REQ-016 On a SYNC match: next state DATA, Active_Out=1 next cycle, bit counter=0, byte counter=0.
REQ-017 In DATA, each accepted bit SHALL fill the next byte position, starting at bit 0.
REQ-018 After the 8th accepted bit: Byte_Out updated and Valid_Out=1 in the following cycle (latency 1).
- First_Out=1 with that pulse if the byte counter was 0.
- Byte counter then increments.
REQ-019 Byte_Out SHALL hold its value between Valid_Out pulses.
REQ-020 Eop_In in DATA with bit counter=0 and byte counter>=1 SHALL produce Done_Out=1 in the next cycle, Active_Out=0 and return to HUNT.
REQ-021 Eop_In in DATA with a partial byte, or with zero bytes, SHALL produce Err_Out=1 in the next cycle with no Done_Out and no Valid_Out for the partial byte, and return to HUNT.
REQ-022 When a byte would complete with the byte counter already at MAX_BYTES:
- that byte is suppressed and Err_Out=1 next cycle;
- state goes to DRAIN, where Active_Out stays 1 and no Valid_Out is produced.
REQ-023 Eop_In in DRAIN SHALL return to HUNT with no Done_Out and no second Err_Out.
REQ-024 Eop_In in HUNT SHALL be ignored and SHALL clear the history register.
REQ-025 Eop_In takes priority: if it coincides with a bit slot, that bit SHALL be discarded.
REQ-026 Skip_In=1 SHALL leave all counters and the history register unchanged.
REQ-027 The byte counter SHALL be clog2(MAX_BYTES+1) bits wide and SHALL never wrap.

Reset
REQ-028 On Rx_Deser_Rst=1, after that clock edge:
- state=HUNT; history register, counters and all outputs are 0;
- Byte_Out=8'h00.
REQ-029 Reset during DATA or DRAIN SHALL abort the packet silently, with no Done_Out or Err_Out pulse.

Configuration
REQ-030 With macro RX_DESER_PID_CHECK_EN defined, the block SHALL add output Rx_Deser_Pid_Err_Out (output, 1 bit).
- It pulses with the first Valid_Out when Byte_Out[7:4] != ~Byte_Out[3:0].
- A PID error SHALL also force Err_Out instead of Done_Out at the end of that packet.
REQ-031 Without RX_DESER_PID_CHECK_EN, the port and the check SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-032 Shared package usb_rx_pkg SHALL hold: the state enumeration, SYNC_PATTERN=8'h80, the MAX_BYTES default and the PID nibble-check helper.
REQ-033 SYNC hunting SHALL be a sub-module usb_sync_detect: inputs are bit, enable and clear; output is a match pulse.

Verification
REQ-034 Bench scenarios:
- SYNC, then bits for 8'hA5 and 8'h3C LSB-first, then Eop -> Valid pulses with A5 (First=1) and 3C, then Done=1 one cycle after Eop.
- SYNC, 8'hE1, Skip_In=1 for 2 cycles between bits 3 and 4 -> Byte_Out=E1; timing extends by 2 cycles only.
- SYNC, 8'hD2, 5 further bits, Eop -> one Valid (D2), then Err=1; Done stays 0.
- MAX_BYTES=4, SYNC plus 5 bytes -> 4 Valid pulses, Err=1 after the 5th byte completes, no 5th Valid; Eop then returns to HUNT with no pulse.
- Reset asserted after 3 bytes of a packet -> all outputs 0 next cycle, no Done/Err; a following packet 8'h69 is received normally.
- With RX_DESER_PID_CHECK_EN: first byte 8'h55 -> Pid_Err=1 and Err at Eop; first byte 8'hE1 -> no Pid_Err and Done at Eop.
